tqvp_jnms_pcm_fifo: RTL

- Downstream stage of the PDM microphone peripheral's CIC3 decimator.
- Captures each 16-bit PCM sample announced by the decimator's valid strobe, which is slow and asynchronous to clk, into a small first-word-fall-through FIFO.
- Exposes head/level/flag signals to the TinyQV register interface and raises an interrupt on a fill threshold or overflow.

---
 rtl/tqvp_jnms_pcm_pkg.sv | 10 +
 rtl/tqvp_jnms_pcm_dcblock.sv | 60 ++++++
 rtl/tqvp_jnms_pcm_fifo.sv | 101 ++++++++++
 3 files changed

// File: rtl/tqvp_jnms_pcm_pkg.sv
// Shared constants for the PDM microphone PCM capture path.
package tqvp_jnms_pcm_pkg;

    localparam int PCM_WIDTH         = 16;
    localparam int PCM_DCBLOCK_SHIFT = 8;

    localparam logic [PCM_WIDTH-1:0] PCM_MAX = 16'h7FFF;
    localparam logic [PCM_WIDTH-1:0] PCM_MIN = 16'h8000;

endpackage

// File: rtl/tqvp_jnms_pcm_dcblock.sv
// One-cycle registered DC-blocking high-pass: y = x - x_prev + y_prev - (y_prev >>> SHIFT),
// evaluated in WIDTH+4 bits and saturated back to the signed WIDTH range.
module tqvp_jnms_pcm_dcblock
    import tqvp_jnms_pcm_pkg::*;
#(
    parameter int WIDTH = PCM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out
);

    localparam int EW = WIDTH + 4;
    localparam logic signed [EW-1:0] SAT_HI = {5'b00000, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_LO = {5'b11111, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] x_prev, y_prev;
    logic signed [EW-1:0]    x_e, xp_e, yp_e, y_sum;
    logic        [WIDTH-1:0] y_sat;

    always_comb begin
        x_e   = EW'(signed'(in));
        xp_e  = EW'(x_prev);
        yp_e  = EW'(y_prev);
        y_sum = x_e - xp_e + yp_e - (yp_e >>> PCM_DCBLOCK_SHIFT);
        if (y_sum > SAT_HI)
            y_sat = SAT_HI[WIDTH-1:0];
        else if (y_sum < SAT_LO)
            y_sat = SAT_LO[WIDTH-1:0];
        else
            y_sat = y_sum[WIDTH-1:0];
    end

    // Saturated output doubles as the feedback state so y_prev never exceeds range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_prev    <= '0;
            y_prev    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            x_prev    <= '0;
            y_prev    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                x_prev <= in;
                y_prev <= y_sat;
                out    <= y_sat;
            end
        end
    end

endmodule

// File: rtl/tqvp_jnms_pcm_fifo.sv
// PCM sample capture FIFO behind the CIC3 decimator: async valid synchroniser,
// edge-detected push, FWFT circular buffer, threshold/overflow irq.
// Optional DC-blocking filter on the write path when TQVP_PCM_DCBLOCK_EN is defined.
module tqvp_jnms_pcm_fifo
    import tqvp_jnms_pcm_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int WIDTH       = PCM_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         pcm_in,
    input  logic                     pcm_valid_in,
    input  logic                     rd_pop,
    input  logic                     clear,
    input  logic [$clog2(DEPTH):0]   thresh,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    // Synchroniser flops followed by one history flop for rising-edge detect.
    logic [SYNC_STAGES:0] vld_pipe;
    logic                 push_raw, push;
    logic [WIDTH-1:0]     wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], pcm_valid_in};
    end

    assign push_raw = vld_pipe[SYNC_STAGES-1] & ~vld_pipe[SYNC_STAGES];

`ifdef TQVP_PCM_DCBLOCK_EN
    tqvp_jnms_pcm_dcblock #(.WIDTH(WIDTH)) u_dcblock (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (push_raw),
        .in        (pcm_in),
        .out_valid (push),
        .out       (wr_data)
    );
`else
    assign push    = push_raw;
    assign wr_data = pcm_in;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_next, rd_next, level_next;
    logic             ovf_next, irq_next, do_push, do_pop;

    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);

    // A pop frees a slot in the same cycle, so push into a full FIFO is legal alongside it.
    always_comb begin
        do_pop     = rd_pop & ~empty;
        do_push    = push & (~full | do_pop);
        wr_next    = wr_ptr + (AW+1)'(do_push);
        rd_next    = rd_ptr + (AW+1)'(do_pop);
        ovf_next   = overflow | (push & full & ~do_pop);
        if (clear) begin
            wr_next  = '0;
            rd_next  = '0;
            ovf_next = 1'b0;
        end
        level_next = wr_next - rd_next;
        irq_next   = ovf_next | ((thresh != '0) && (level_next >= thresh));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            wr_ptr   <= wr_next;
            rd_ptr   <= rd_next;
            overflow <= ovf_next;
            irq      <= irq_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
